// File: rtl/dm_cache_fsm_if.sv
// CPU load/store port and block-wide memory port of the direct-mapped cache.
// master = CPU/memory side, slave = cache controller.
interface dm_cache_fsm_if;
  logic         cpu_req_valid;
  logic         cpu_req_rw;
  logic [31:0]  cpu_req_addr;
  logic [31:0]  cpu_req_data;
  logic [31:0]  cpu_res_data;
  logic         cpu_res_ready;
  logic         mem_req_valid;
  logic         mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic [127:0] mem_data_data;
  logic         mem_data_ready;

  modport master (
    output cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_data,
    output mem_data_data, mem_data_ready,
    input  cpu_res_data, cpu_res_ready,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
  );

  modport slave (
    input  cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_data,
    input  mem_data_data, mem_data_ready,
    output cpu_res_data, cpu_res_ready,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
  );
endinterface

// File: rtl/dm_cache_fsm.sv
// Direct-mapped write-back/write-allocate cache: 1024 x 128-bit lines,
// miss handling via optional dirty write-back followed by a block fill.
module dm_cache_fsm (
  input  logic           clk,
  input  logic           rst,
  dm_cache_fsm_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, COMPARE_TAG, ALLOCATE, WRITE_BACK} state_t;

  typedef struct packed {
    logic        rw;
    logic [17:0] tag;
    logic [9:0]  idx;
    logic [1:0]  wsel;
    logic [31:0] wdata;
  } req_t;

  state_t       state;
  req_t         req;
  logic [1023:0] valid, dirty;
  logic [127:0] data_mem [1024];
  logic [17:0]  tag_mem  [1024];

  logic [127:0] line;
  logic [17:0]  otag;
  logic         hit;
  logic         unused;

  // byte offset is ignored: all accesses are word-aligned
  assign unused = &{1'b0, bus.cpu_req_addr[1:0]};

  assign line = data_mem[req.idx];
  assign otag = tag_mem[req.idx];
  assign hit  = (state == COMPARE_TAG) && valid[req.idx] && (otag == req.tag);

  always_comb begin
    bus.cpu_res_ready = hit;
    bus.cpu_res_data  = hit ? line[req.wsel*32 +: 32] : 32'h0;
    bus.mem_req_valid = (state == WRITE_BACK) || (state == ALLOCATE);
    bus.mem_req_rw    = (state == WRITE_BACK);
    bus.mem_req_addr  = 32'h0;
    bus.mem_req_data  = 128'h0;
    if (state == WRITE_BACK) begin
      bus.mem_req_addr = {otag, req.idx, 4'h0};
      bus.mem_req_data = line;
    end else if (state == ALLOCATE) begin
      bus.mem_req_addr = {req.tag, req.idx, 4'h0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      req   <= '0;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cpu_req_valid) begin
          req.rw    <= bus.cpu_req_rw;
          req.tag   <= bus.cpu_req_addr[31:14];
          req.idx   <= bus.cpu_req_addr[13:4];
          req.wsel  <= bus.cpu_req_addr[3:2];
          req.wdata <= bus.cpu_req_data;
          state     <= COMPARE_TAG;
        end
        COMPARE_TAG: begin
          if (hit) begin
            if (req.rw) dirty[req.idx] <= 1'b1;
            state <= IDLE;
          end else if (valid[req.idx] && dirty[req.idx]) begin
            state <= WRITE_BACK;
          end else begin
            state <= ALLOCATE;
          end
        end
        WRITE_BACK: if (bus.mem_data_ready) state <= ALLOCATE;
        ALLOCATE: if (bus.mem_data_ready) begin
          valid[req.idx] <= 1'b1;
          dirty[req.idx] <= 1'b0;
          state          <= COMPARE_TAG;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Arrays carry no reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (hit && req.rw)
        data_mem[req.idx][req.wsel*32 +: 32] <= req.wdata;
      if ((state == ALLOCATE) && bus.mem_data_ready) begin
        data_mem[req.idx] <= bus.mem_data_data;
        tag_mem[req.idx]  <= req.tag;
      end
    end
  end
endmodule

// File: tb/tb_dm_cache_fsm.sv
// Directed bench for dm_cache_fsm: hits, clean/dirty misses and reset mid-fill.
module tb_dm_cache_fsm;
  logic clk, rst;
  int nvec = 0;
  int nbad = 0;

  dm_cache_fsm_if bus ();
  dm_cache_fsm dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] BLK_A = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
  localparam logic [127:0] BLK_B = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444};
  localparam logic [127:0] BLK_C = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
  localparam logic [127:0] WB_EXP = {32'h33333333, 32'h89ABCDEF, 32'h01234567, 32'h00000000};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cpu"}, {95'h0, bus.cpu_res_ready, bus.cpu_res_data}, 128'h0);
    chk({tag, "_mem"}, {94'h0, bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr}, 128'h0);
    chk({tag, "_mdata"}, bus.mem_req_data, 128'h0);
  endtask

  // Returns #1 after the capture edge, i.e. inside COMPARE_TAG.
  task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_rw    = rw;
    bus.cpu_req_addr  = addr;
    bus.cpu_req_data  = wd;
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_data  = 32'h0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mem_done(input logic [127:0] blk);
    bus.mem_data_data  = blk;
    bus.mem_data_ready = 1'b1;
    step();
    bus.mem_data_ready = 1'b0;
    bus.mem_data_data  = 128'h0;
  endtask

  task automatic expect_hit(input string tag, input logic [31:0] d);
    chk({tag, "_rdy"}, {127'h0, bus.cpu_res_ready}, 128'h1);
    chk({tag, "_data"}, {96'h0, bus.cpu_res_data}, {96'h0, d});
    chk({tag, "_nomem"}, {127'h0, bus.mem_req_valid}, 128'h0);
    step();
    chk({tag, "_pulse"}, {127'h0, bus.cpu_res_ready}, 128'h0);
  endtask

  initial begin
    rst = 1'b0;
    bus.cpu_req_valid = 1'b0; bus.cpu_req_rw = 1'b0;
    bus.cpu_req_addr = 32'h0; bus.cpu_req_data = 32'h0;
    bus.mem_data_data = 128'h0; bus.mem_data_ready = 1'b0;
    #23;
    chk_quiet("reset");
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk_quiet("idle");

    // cold read miss
    issue(1'b0, 32'h80004000, 32'h0);
    chk("cold_cmp_rdy", {127'h0, bus.cpu_res_ready}, 128'h0);
    step();
    chk("cold_alloc", {94'h0, bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr}, {94'h0, 2'b10, 32'h80004000});
    step();
    chk("cold_alloc_hold", {94'h0, bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr}, {94'h0, 2'b10, 32'h80004000});
    mem_done(BLK_A);
    expect_hit("cold_done", 32'h00000000);
    chk("cold_vd", {126'h0, dut.valid[0], dut.dirty[0]}, 128'h2);

    // write hit returns pre-write word
    issue(1'b1, 32'h80004004, 32'h01234567);
    expect_hit("wr_hit", 32'h11111111);
    chk("wr_dirty", {127'h0, dut.dirty[0]}, 128'h1);
    issue(1'b0, 32'h80004004, 32'h0);
    expect_hit("rd_back", 32'h01234567);

    // read miss at index 1
    issue(1'b0, 32'h80004010, 32'h0);
    chk("idx1_cmp_rdy", {127'h0, bus.cpu_res_ready}, 128'h0);
    step();
    chk("idx1_alloc", {94'h0, bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr}, {94'h0, 2'b10, 32'h80004010});
    mem_done(BLK_B);
    expect_hit("idx1_done", 32'h44444444);
    chk("idx0_kept", {126'h0, dut.valid[0], dut.dirty[0]}, 128'h3);

    // write to resident line
    issue(1'b1, 32'h80004008, 32'h89ABCDEF);
    expect_hit("wr2_hit", 32'h22222222);
    issue(1'b0, 32'h80004000, 32'h0);
    expect_hit("rd_w0", 32'h00000000);
    issue(1'b0, 32'h80004004, 32'h0);
    expect_hit("rd_w1", 32'h01234567);
    issue(1'b0, 32'h80004008, 32'h0);
    expect_hit("rd_w2", 32'h89ABCDEF);

    // dirty eviction
    issue(1'b0, 32'h80008000, 32'h0);
    chk("evict_cmp_rdy", {127'h0, bus.cpu_res_ready}, 128'h0);
    step();
    chk("wb_req", {94'h0, bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr}, {94'h0, 2'b11, 32'h80004000});
    chk("wb_data", bus.mem_req_data, WB_EXP);
    step();
    chk("wb_hold", {94'h0, bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr}, {94'h0, 2'b11, 32'h80004000});
    mem_done(128'h0);
    chk("evict_alloc", {94'h0, bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr}, {94'h0, 2'b10, 32'h80008000});
    mem_done(BLK_C);
    expect_hit("evict_done", 32'hAAAAAAAA);
    chk("evict_clean", {126'h0, dut.valid[0], dut.dirty[0]}, 128'h2);

    // reset mid-fill
    issue(1'b0, 32'h80004000, 32'h0);
    step();
    chk("rst_pre_alloc", {94'h0, bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr}, {94'h0, 2'b10, 32'h80004000});
    #1 rst = 1'b0;
    #1 chk_quiet("rst_mid");
    @(negedge clk); rst = 1'b1;
    issue(1'b0, 32'h80004000, 32'h0);
    chk("post_rst_miss", {127'h0, bus.cpu_res_ready}, 128'h0);
    step();
    chk("post_rst_alloc", {94'h0, bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr}, {94'h0, 2'b10, 32'h80004000});
    mem_done(BLK_A);
    expect_hit("post_rst_done", 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
